// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals shared by the memory arbiter and its environment.
// A requester raises *_req and holds it (with its address and data stable) until it sees
// the one-cycle *_done pulse, then drops *_req during that DONE cycle. The RAM returns
// ram_din one cycle after ram_addr.
interface mem_arbiter_if #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
);
   logic                if_req;
   logic [ADDR_LEN-1:0] if_addr;
   logic                if_flush;
   logic [DATA_LEN-1:0] if_data;
   logic                if_done;

   logic                mem_req;
   logic                mem_we;
   logic [ADDR_LEN-1:0] mem_addr;
   logic [1:0]          mem_len;
   logic [DATA_LEN-1:0] mem_wdata;
   logic [DATA_LEN-1:0] mem_rdata;
   logic                mem_done;

   logic [ADDR_LEN-1:0] ram_addr;
   logic [7:0]          ram_dout;
   logic                ram_wr;
   logic [7:0]          ram_din;

   logic                busy;

   modport master (
      output if_req, if_addr, if_flush,
      output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
      output ram_din,
      input  if_data, if_done, mem_rdata, mem_done,
      input  ram_addr, ram_dout, ram_wr, busy
   );

   modport slave (
      input  if_req, if_addr, if_flush,
      input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
      input  ram_din,
      output if_data, if_done, mem_rdata, mem_done,
      output ram_addr, ram_dout, ram_wr, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter: an instruction-fetch port and a load/store port share one
// byte-wide synchronous RAM; load/store wins when both request in the same IDLE cycle.
module mem_arbiter #(
   parameter int ADDR_LEN = 32,
   parameter int DATA_LEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus,
   output logic [1:0]   o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [2:0]          r_idx;
   logic [2:0]          w_idx_next;
   logic [ADDR_LEN-1:0] r_base;
   logic [2:0]          r_len;
   logic                r_owner_if;
   logic [DATA_LEN-1:0] r_wdata;
   logic [DATA_LEN-1:0] r_rbuf;
   logic [DATA_LEN-1:0] r_if_data;
   logic [DATA_LEN-1:0] r_mem_rdata;

   logic                w_accept_mem;
   logic                w_accept_if;
   logic                w_capture;
   logic                w_rd_last;
   logic [2:0]          w_len_dec;
   logic [1:0]          w_byte_sel;
   logic [ADDR_LEN-1:0] w_idx_addr;
   logic [DATA_LEN-1:0] w_rbuf_next;
   logic [ADDR_LEN-1:0] w_ram_addr;
   logic [7:0]          w_ram_dout;
   logic                w_ram_wr;

   always_comb begin
      w_len_dec = 3'd4;
      if (bus.mem_len == 2'b00)
         w_len_dec = 3'd1;
      else if (bus.mem_len == 2'b01)
         w_len_dec = 3'd2;
   end

   // Wraps naturally at 2^ADDR_LEN; read data for address idx lands one cycle later, hence idx-1.
   assign w_idx_addr = r_base + {{(ADDR_LEN-3){1'b0}}, r_idx};
   assign w_byte_sel = r_idx[1:0] - 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= 3'd0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_accept_mem = 1'b0;
      w_accept_if  = 1'b0;
      w_capture    = 1'b0;
      w_rd_last    = 1'b0;
      w_rbuf_next  = r_rbuf;
      w_ram_addr   = '0;
      w_ram_dout   = 8'h00;
      w_ram_wr     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_idx_next = 3'd0;
            if (bus.mem_req) begin
               w_accept_mem = 1'b1;
               w_state_next = bus.mem_we ? S_WR : S_RD;
            end else if (bus.if_req && !bus.if_flush) begin
               w_accept_if  = 1'b1;
               w_state_next = S_RD;
            end
         end
         S_RD: begin
            if (r_idx < r_len)
               w_ram_addr = w_idx_addr;
            if (r_idx != 3'd0) begin
               w_capture = 1'b1;
               w_rbuf_next[{w_byte_sel, 3'b000} +: 8] = bus.ram_din;
            end
            if (r_owner_if && bus.if_flush) begin
               w_state_next = S_IDLE;
               w_idx_next   = 3'd0;
            end else if (r_idx == r_len) begin
               w_rd_last    = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_idx_next = r_idx + 3'd1;
            end
         end
         S_WR: begin
            w_ram_addr = w_idx_addr;
            w_ram_dout = r_wdata[{r_idx[1:0], 3'b000} +: 8];
            w_ram_wr   = 1'b1;
            if (r_idx == r_len - 3'd1) begin
               w_state_next = S_DONE;
               w_idx_next   = 3'd0;
            end else begin
               w_idx_next = r_idx + 3'd1;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
            w_idx_next   = 3'd0;
         end
         default: begin
            w_state_next = S_IDLE;
            w_idx_next   = 3'd0;
         end
      endcase
   end

   // Reads assemble in r_rbuf and are published only on completion, so a flushed fetch leaves if_data intact.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base      <= '0;
         r_len       <= 3'd0;
         r_owner_if  <= 1'b0;
         r_wdata     <= '0;
         r_rbuf      <= '0;
         r_if_data   <= '0;
         r_mem_rdata <= '0;
      end else begin
         if (w_accept_mem) begin
            r_base     <= bus.mem_addr;
            r_len      <= w_len_dec;
            r_owner_if <= 1'b0;
            r_wdata    <= bus.mem_wdata;
            r_rbuf     <= '0;
         end else if (w_accept_if) begin
            r_base     <= bus.if_addr;
            r_len      <= 3'd4;
            r_owner_if <= 1'b1;
            r_rbuf     <= '0;
         end else if (w_capture) begin
            r_rbuf <= w_rbuf_next;
         end
         if (w_rd_last) begin
            if (r_owner_if)
               r_if_data <= w_rbuf_next;
            else
               r_mem_rdata <= w_rbuf_next;
         end
      end
   end

   assign bus.ram_addr  = w_ram_addr;
   assign bus.ram_dout  = w_ram_dout;
   assign bus.ram_wr    = w_ram_wr;
   assign bus.if_data   = r_if_data;
   assign bus.mem_rdata = r_mem_rdata;
   assign bus.if_done   = (r_state == S_DONE) &&  r_owner_if;
   assign bus.mem_done  = (r_state == S_DONE) && !r_owner_if;
   assign bus.busy      = (r_state != S_IDLE);
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences, and
// random traffic checked against a byte-array reference memory.
module tb_mem_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;
   int         n_checks;
   int         n_errors;

   mem_arbiter_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

   mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic [7:0]  ram_m [bit [31:0]];
   logic [7:0]  ref_m [bit [31:0]];
   wr_t         wlog[$];
   logic [31:0] exp_q[$];

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram_m.exists(a) ? ram_m[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_m.exists(a) ? ref_m[a] : 8'h00;
   endfunction

   // Synchronous byte RAM: write on strobe, read data one cycle after the address.
   always @(posedge clk) begin
      if (bus.ram_wr === 1'b1) begin
         ram_m[bus.ram_addr] = bus.ram_dout;
         wlog.push_back({bus.ram_addr, bus.ram_dout});
      end
      bus.ram_din <= ram_rd(bus.ram_addr);
   end

   function automatic int nbytes(input logic [1:0] len);
      return (len == 2'b00) ? 1 : ((len == 2'b01) ? 2 : 4);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < n; i++)
         v = v | ({24'h0, ref_rd(a + 32'(i))} << (8 * i));
      return v;
   endfunction

   task automatic preload(input logic [31:0] a, input logic [7:0] d);
      ram_m[a] = d;
      ref_m[a] = d;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // kind: 0 = instruction fetch, 1 = load, 2 = store
   task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input int exp_lat, input string name);
      int          n;
      int          lat;
      bit          got_done;
      bit          other_done;
      logic [31:0] got;
      n          = (kind == 0) ? 4 : nbytes(len);
      lat        = 0;
      got_done   = 1'b0;
      other_done = 1'b0;
      got        = 32'h0;
      check({name, " idle before"}, 32'(bus.busy), 32'd0);
      wlog.delete();
      if (kind != 2) exp_q.push_back(exp_data);
      if (kind == 0) begin
         bus.if_addr = addr;
         bus.if_req  = 1'b1;
      end else begin
         bus.mem_we    = (kind == 2);
         bus.mem_addr  = addr;
         bus.mem_len   = len;
         bus.mem_wdata = wdata;
         bus.mem_req   = 1'b1;
      end
      while (!got_done && lat < 40) begin
         tick();
         lat++;
         if ((kind == 0) ? bus.mem_done : bus.if_done) other_done = 1'b1;
         if ((kind == 0) ? bus.if_done : bus.mem_done) begin
            got_done = 1'b1;
            got      = (kind == 0) ? bus.if_data : bus.mem_rdata;
         end
      end
      bus.if_req  = 1'b0;
      bus.mem_req = 1'b0;
      check({name, " done seen"}, 32'(got_done), 32'd1);
      check({name, " latency"}, 32'(lat), 32'(exp_lat));
      check({name, " wrong port done"}, 32'(other_done), 32'd0);
      if (kind != 2) begin
         check({name, " data"}, got, exp_q.pop_front());
      end else begin
         check({name, " write count"}, 32'(wlog.size()), 32'(n));
         for (int i = 0; i < n; i++) begin
            logic [31:0] ea;
            logic [7:0]  ed;
            ea = addr + 32'(i);
            ed = wdata[8*i +: 8];
            if (i < wlog.size()) begin
               check($sformatf("%s wr addr %0d", name, i), wlog[i].addr, ea);
               check($sformatf("%s wr byte %0d", name, i), 32'(wlog[i].data), 32'(ed));
            end
            ref_m[ea] = ed;
         end
      end
      tick();
      check({name, " done one cycle"}, 32'((kind == 0) ? bus.if_done : bus.mem_done), 32'd0);
      check({name, " idle after"}, 32'(bus.busy), 32'd0);
   endtask

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      rst           = 1'b1;
      bus.if_req    = 1'b0;
      bus.if_addr   = 32'h0;
      bus.if_flush  = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_len   = 2'b00;
      bus.mem_wdata = 32'h0;

      preload(32'h100, 8'h13); preload(32'h101, 8'h05);
      preload(32'h102, 8'h00); preload(32'h103, 8'h00);
      preload(32'h200, 8'h8F);
      preload(32'h300, 8'h34); preload(32'h301, 8'h12);
      preload(32'h600, 8'hA4); preload(32'h601, 8'hA3);
      preload(32'h602, 8'hA2); preload(32'h603, 8'hA1);

      // Reset state
      repeat (3) tick();
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset ram_wr", 32'(bus.ram_wr), 32'd0);
      check("reset ram_addr", bus.ram_addr, 32'd0);
      check("reset ram_dout", 32'(bus.ram_dout), 32'd0);
      check("reset if_done", 32'(bus.if_done), 32'd0);
      check("reset mem_done", 32'(bus.mem_done), 32'd0);
      check("reset if_data", bus.if_data, 32'd0);
      check("reset mem_rdata", bus.mem_rdata, 32'd0);
      check("reset debug state", 32'(dbg_state), 32'd0);
      rst = 1'b0;
      tick();

      // Directed vector table
      vecs[0]  = '{0, 32'h0000_0100, 2'b10, 32'h0,         32'h0000_0513, 6};
      vecs[1]  = '{1, 32'h0000_0300, 2'b01, 32'h0,         32'h0000_1234, 4};
      vecs[2]  = '{1, 32'h0000_0200, 2'b00, 32'h0,         32'h0000_008F, 3};
      vecs[3]  = '{2, 32'hFFFF_FFFE, 2'b10, 32'hDEAD_BEEF, 32'h0,         5};
      vecs[4]  = '{1, 32'hFFFF_FFFE, 2'b10, 32'h0,         32'hDEAD_BEEF, 6};
      vecs[5]  = '{1, 32'hFFFF_FFFF, 2'b01, 32'h0,         32'h0000_ADBE, 4};
      vecs[6]  = '{2, 32'h0000_0400, 2'b00, 32'h1234_5678, 32'h0,         2};
      vecs[7]  = '{1, 32'h0000_0400, 2'b10, 32'h0,         32'h0000_0078, 6};
      vecs[8]  = '{2, 32'h0000_0500, 2'b01, 32'hAABB_CCDD, 32'h0,         3};
      vecs[9]  = '{1, 32'h0000_0500, 2'b11, 32'h0,         32'h0000_CCDD, 6};
      vecs[10] = '{1, 32'h0000_0100, 2'b11, 32'h0,         32'h0000_0513, 6};
      vecs[11] = '{0, 32'hFFFF_FFFF, 2'b00, 32'h0,         32'h00DE_ADBE, 6};
      vecs[12] = '{1, 32'h0000_0301, 2'b00, 32'h0,         32'h0000_0012, 3};
      for (int i = 0; i < 13; i++)
         run_txn(vecs[i].kind, vecs[i].addr, vecs[i].len, vecs[i].wdata,
                 vecs[i].exp_data, vecs[i].exp_lat, $sformatf("vec%0d", i));

      // Simultaneous requests: load first, fetch in the following IDLE
      begin
         int          k;
         int          k_mem;
         int          k_if;
         logic [31:0] mem_d;
         logic [31:0] if_d;
         k = 0; k_mem = -1; k_if = -1; mem_d = 32'h0; if_d = 32'h0;
         bus.mem_we = 1'b0; bus.mem_addr = 32'h200; bus.mem_len = 2'b00; bus.mem_req = 1'b1;
         bus.if_addr = 32'h100; bus.if_req = 1'b1;
         while (k_if < 0 && k < 30) begin
            tick();
            k++;
            if (bus.mem_done) begin
               k_mem = k;
               mem_d = bus.mem_rdata;
               bus.mem_req = 1'b0;
            end
            if (bus.if_done) begin
               k_if = k;
               if_d = bus.if_data;
            end
         end
         bus.if_req = 1'b0;
         check("both req mem_done cycle", 32'(k_mem), 32'd3);
         check("both req mem_rdata", mem_d, 32'h0000_008F);
         check("both req if_done cycle", 32'(k_if), 32'd10);
         check("both req if_data", if_d, 32'h0000_0513);
         tick();
      end

      // Fetch flushed on its third RD cycle; pending load accepted at once
      begin
         int          k;
         bit          saw_if;
         k = 0; saw_if = 1'b0;
         bus.if_addr = 32'h600; bus.if_req = 1'b1;
         repeat (2) begin
            tick(); k++;
            if (bus.if_done) saw_if = 1'b1;
         end
         bus.mem_we = 1'b0; bus.mem_addr = 32'h300; bus.mem_len = 2'b01; bus.mem_req = 1'b1;
         tick(); k++;
         if (bus.if_done) saw_if = 1'b1;
         bus.if_flush = 1'b1; bus.if_req = 1'b0;
         tick(); k++;
         check("flush idle next cycle", 32'(bus.busy), 32'd0);
         bus.if_flush = 1'b0;
         while (!bus.mem_done && k < 30) begin
            tick(); k++;
            if (bus.if_done) saw_if = 1'b1;
         end
         bus.mem_req = 1'b0;
         check("flush mem_done cycle", 32'(k), 32'd8);
         check("flush mem_rdata", bus.mem_rdata, 32'h0000_1234);
         check("flush no if_done", 32'(saw_if), 32'd0);
         check("flush if_data kept", bus.if_data, 32'h0000_0513);
         tick();
      end

      // Flush held in IDLE blocks fetch acceptance but not load/store
      begin
         bit saw_busy;
         saw_busy = 1'b0;
         bus.if_addr = 32'h100; bus.if_req = 1'b1; bus.if_flush = 1'b1;
         repeat (4) begin
            tick();
            if (bus.busy) saw_busy = 1'b1;
         end
         bus.if_req = 1'b0;
         check("idle flush blocks fetch", 32'(saw_busy), 32'd0);
         run_txn(1, 32'h200, 2'b00, 32'h0, 32'h0000_008F, 3, "load under flush");
         bus.if_flush = 1'b0;
      end

      // Reset in the middle of a word store
      begin
         bit saw_done;
         saw_done = 1'b0;
         wlog.delete();
         bus.mem_we = 1'b1; bus.mem_addr = 32'h700; bus.mem_len = 2'b10;
         bus.mem_wdata = 32'h1122_3344; bus.mem_req = 1'b1;
         tick();
         tick();
         rst = 1'b1;
         tick();
         check("rst mid store ram_wr", 32'(bus.ram_wr), 32'd0);
         check("rst mid store busy", 32'(bus.busy), 32'd0);
         check("rst mid store mem_done", 32'(bus.mem_done), 32'd0);
         check("rst mid store mem_rdata", bus.mem_rdata, 32'd0);
         check("rst mid store if_data", bus.if_data, 32'd0);
         check("rst mid store bytes written", 32'(wlog.size()), 32'd2);
         ref_m[32'h700] = 8'h44;
         ref_m[32'h701] = 8'h33;
         rst = 1'b0;
         bus.mem_req = 1'b0;
         repeat (8) begin
            tick();
            if (bus.mem_done || bus.busy) saw_done = 1'b1;
         end
         check("rst mid store stays quiet", 32'(saw_done), 32'd0);
      end

      // Random traffic against the reference memory
      for (int t = 0; t < 40; t++) begin
         int          kind;
         int          n;
         logic [31:0] a;
         logic [1:0]  len;
         logic [31:0] wd;
         logic [31:0] ed;
         kind = int'($urandom_range(0, 2));
         a    = ($urandom_range(0, 1) == 0) ? (32'h1000 + 32'($urandom_range(0, 31)))
                                            : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
         len  = 2'($urandom_range(0, 3));
         wd   = $urandom;
         n    = (kind == 0) ? 4 : nbytes(len);
         ed   = (kind == 2) ? 32'h0 : ref_read(a, n);
         run_txn(kind, a, len, wd, ed, (kind == 2) ? n + 1 : n + 2, $sformatf("rand%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_LEN, 32, address width of requester and RAM addresses.
REQ-002 Parameter: DATA_LEN, 32, requester data width (4 bytes).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 if_req  in  1  instruction fetch request, level; held until if_done.
REQ-006 if_addr  in  ADDR_LEN  fetch byte address; stable while if_req high.
REQ-007 if_flush  in  1  abort pending/active fetch (branch/jump taken).
REQ-008 if_data  out  DATA_LEN  fetched word.
REQ-009 if_done  out  1  one-cycle pulse; if_data valid.
REQ-010 mem_req  in  1  load/store request, level; held until mem_done.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_addr  in  ADDR_LEN  load/store byte address.
REQ-013 mem_len  in  2  00 byte, 01 half, 10/11 word.
REQ-014 mem_wdata  in  DATA_LEN  store data, little-endian, low bytes used.
REQ-015 mem_rdata  out  DATA_LEN  load data, zero-extended.
REQ-016 mem_done  out  1  one-cycle pulse; load data valid / store complete.
REQ-017 ram_addr  out  ADDR_LEN  byte-wide RAM address.
REQ-018 ram_dout  out  8  RAM write byte.
REQ-019 ram_wr  out  1  RAM write strobe.
REQ-020 ram_din  in  8  RAM read byte, valid one cycle after ram_addr presented.
REQ-021 busy  out  1  high whenever state != IDLE.

Function
REQ-022 States SHALL be IDLE, RD, WR, DONE; a counter idx (0..4) and registered base address, length N (1/2/4), and owner (IF or MEM).
REQ-023 Requests SHALL be sampled only in IDLE; mem_req has priority over if_req when both high.
REQ-024 IDLE: mem_req & mem_we -> WR; mem_req & !mem_we -> RD (owner MEM); else if_req & !if_flush -> RD (owner IF, N=4); idx cleared; base/N/wdata latched.
REQ-025 RD: ram_addr = base+idx while idx<N, ram_wr=0; when idx>=1, ram_din captured into byte idx-1 of result; at idx==N last byte captured, -> DONE; otherwise idx increments.
REQ-026 WR: ram_addr = base+idx, ram_dout = latched wdata byte idx, ram_wr=1; at idx==N-1 -> DONE.
REQ-027 DONE: exactly one cycle; owner's done output high, other done low; -> IDLE.
REQ-028 Latency from accepting IDLE cycle: read N bytes -> done N+2 cycles later; write N bytes -> done N+1 cycles later.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_LEN.
REQ-030 Unread upper bytes of mem_rdata SHALL be 0; if_data/mem_rdata SHALL hold value until the owner's next read completes.
REQ-031 if_flush high during RD with owner IF -> IDLE next edge, no if_done, if_data unchanged; if_flush ignored for MEM owner.
REQ-032 if_flush high in IDLE suppresses IF acceptance that cycle; mem_req still accepted.
REQ-033 In IDLE and DONE: ram_wr=0, ram_addr=0, ram_dout=0.
REQ-034 Requester drops req in the DONE cycle; the DONE cycle guarantees no re-acceptance of the same request.

Reset
REQ-035 rst high at an edge SHALL force IDLE, idx=0, and all outputs 0 (ram_wr, if_done, mem_done, busy, if_data, mem_rdata, ram_addr, ram_dout) from the next cycle, aborting any access mid-sequence without a done pulse.

Verification
REQ-036 IF word read at 0x100, RAM bytes 0x13,0x05,0x00,0x00 -> if_done 6 cycles after acceptance, if_data=0x00000513.
REQ-037 Both req same cycle: mem load byte 0x200 (RAM 0x8F) and if_req -> mem_done first, mem_rdata=0x0000008F, then IF accepted in following IDLE.
REQ-038 Store word 0xDEADBEEF at 0xFFFFFFFE -> ram_wr 4 cycles, addrs 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 bytes EF,BE,AD,DE, mem_done 5 cycles after acceptance.
REQ-039 if_flush on third RD cycle of IF read -> IDLE next cycle, no if_done, if_data unchanged, pending mem_req accepted immediately.
REQ-040 rst during WR after 2 bytes of word store -> ram_wr=0, busy=0, no mem_done next cycle.
REQ-041 Half load at 0x300 (bytes 0x34,0x12) -> mem_rdata=0x00001234, mem_done 4 cycles after acceptance.
